// File: rtl/rf_tv_pkg.sv
// Shared constants for the 1-bit RF TV modulator:
// channel tuning words at 200 MHz clkp and default AM densities.
package rf_tv_pkg;

    localparam int ACC_W_DEF   = 16;
    localparam int LEVEL_W_DEF = 4;
    localparam int DENS_W_DEF  = 8;

    // 62.25 MHz carrier at 200 MHz clkp
    localparam logic [15:0] FTW_CH4 = 16'd20398;

    // 75 % density at black, 12.5 % asymptote at white
    localparam logic [7:0] DENS_BLACK_DEF = 8'd192;
    localparam logic [7:0] DENS_WHITE_DEF = 8'd32;

endpackage

// File: rtl/rf_tv_modulator_if.sv
// Tuning-word valid/ready channel into the modulator.
// The master offers a word; the slave reports a free pending slot.
interface rf_tv_modulator_if
    import rf_tv_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
);
    logic [ACC_W-1:0] ftw_in;
    logic             ftw_valid;
    logic             ftw_ready;

    modport master (
        output ftw_in,
        output ftw_valid,
        input  ftw_ready
    );

    modport slave (
        input  ftw_in,
        input  ftw_valid,
        output ftw_ready
    );
endinterface

// File: rtl/rf_sd_gate.sv
// Sigma-delta pulse gate: converts the video level to a carrier
// pulse density and decides, once per carrier period, pass or drop.
module rf_sd_gate
    import rf_tv_pkg::*;
#(
    parameter int                LEVEL_W    = LEVEL_W_DEF,
    parameter int                DENS_W     = DENS_W_DEF,
    parameter logic [DENS_W-1:0] DENS_BLACK = DENS_BLACK_DEF,
    parameter logic [DENS_W-1:0] DENS_WHITE = DENS_WHITE_DEF
) (
    input  logic               clkp,
    input  logic               rst_n,
    input  logic               step,
    input  logic               sync_n,
    input  logic [LEVEL_W-1:0] video_q,
    output logic               gate
);

    localparam int PW = LEVEL_W + DENS_W;
    localparam logic [DENS_W-1:0] SPAN = DENS_BLACK - DENS_WHITE;

    logic [PW-1:0]     prod;
    logic [DENS_W-1:0] dens;
    logic [DENS_W:0]   sd_n;
    logic [DENS_W-1:0] sd_q, sd_d;
    logic              gate_q, gate_d;

    // Density falls linearly from black toward the white asymptote;
    // decisions happen only on carrier falling edges so a pulse is
    // never chopped mid-half.
    always_comb begin
        prod   = {{DENS_W{1'b0}}, video_q} * {{LEVEL_W{1'b0}}, SPAN};
        dens   = DENS_BLACK - prod[LEVEL_W +: DENS_W];
        sd_n   = {1'b0, sd_q} + {1'b0, dens};
        sd_d   = sd_q;
        gate_d = gate_q;
        if (step) begin
            if (!sync_n) begin
                gate_d = 1'b1;
            end else begin
                gate_d = sd_n[DENS_W];
                sd_d   = sd_n[DENS_W-1:0];
            end
        end
    end

    // Accumulator and gate state
    always_ff @(posedge clkp) begin
        if (!rst_n) begin
            sd_q   <= '0;
            gate_q <= 1'b0;
        end else begin
            sd_q   <= sd_d;
            gate_q <= gate_d;
        end
    end

    assign gate = gate_q;

endmodule

// File: rtl/rf_tv_modulator.sv
// 1-bit RF TV modulator: phase-accumulator square carrier with
// negative AM by pulse gating; tuning words retune at sync tips.
module rf_tv_modulator
    import rf_tv_pkg::*;
#(
    parameter int                ACC_W      = ACC_W_DEF,
    parameter int                LEVEL_W    = LEVEL_W_DEF,
    parameter int                DENS_W     = DENS_W_DEF,
    parameter logic [ACC_W-1:0]  FTW_RESET  = FTW_CH4,
    parameter logic [DENS_W-1:0] DENS_BLACK = DENS_BLACK_DEF,
    parameter logic [DENS_W-1:0] DENS_WHITE = DENS_WHITE_DEF
) (
    input  logic               clkp,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               csync,
    input  logic [LEVEL_W-1:0] video,
    rf_tv_modulator_if.slave   ftw,
    output logic               line_start,
    output logic               rfv
);

    logic               csync_q, csync_dly_q;
    logic [LEVEL_W-1:0] video_q;
    logic               line_start_q;
    logic [ACC_W-1:0]   phase_q, phase_d;
    logic               msb_dly_q;
    logic [ACC_W-1:0]   ftw_act_q;
    logic [ACC_W-1:0]   pend_q;
    logic               pend_full_q;
    logic               rfv_q;
    logic               carrier;
    logic               step;
    logic               gate;
    logic               accept;

    assign carrier = phase_q[ACC_W-1];
    assign step    = msb_dly_q & ~carrier;
    assign phase_d = phase_q + ftw_act_q;
    assign accept  = ftw.ftw_valid & ~pend_full_q;

    // Input synchronisation and sync falling-edge detection
    always_ff @(posedge clkp) begin
        if (!rst_n) begin
            csync_q      <= 1'b1;
            csync_dly_q  <= 1'b1;
            video_q      <= '0;
            line_start_q <= 1'b0;
        end else begin
            csync_q      <= csync;
            csync_dly_q  <= csync_q;
            video_q      <= video;
            line_start_q <= csync_dly_q & ~csync_q;
        end
    end

    // Free-running phase, carrier edge history and gated output
    always_ff @(posedge clkp) begin
        if (!rst_n) begin
            phase_q   <= '0;
            msb_dly_q <= 1'b0;
            rfv_q     <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            msb_dly_q <= carrier;
            rfv_q     <= enable & carrier & gate;
        end
    end

    // One-slot tuning word buffer, committed only at a line start
    // so the carrier frequency never changes inside active video
    always_ff @(posedge clkp) begin
        if (!rst_n) begin
            ftw_act_q   <= FTW_RESET;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
        end else if (accept) begin
            pend_q      <= ftw.ftw_in;
            pend_full_q <= 1'b1;
        end else if (line_start_q && pend_full_q) begin
            ftw_act_q   <= pend_q;
            pend_full_q <= 1'b0;
        end
    end

    rf_sd_gate #(
        .LEVEL_W    (LEVEL_W),
        .DENS_W     (DENS_W),
        .DENS_BLACK (DENS_BLACK),
        .DENS_WHITE (DENS_WHITE)
    ) u_gate (
        .clkp    (clkp),
        .rst_n   (rst_n),
        .step    (step),
        .sync_n  (csync_q),
        .video_q (video_q),
        .gate    (gate)
    );

    assign ftw.ftw_ready = ~pend_full_q;
    assign line_start    = line_start_q;
    assign rfv           = rfv_q;

endmodule
